// File: rtl/branch_ckpt_buffer_pkg.sv
// Shared types and default sizing for the branch checkpoint buffer.
// The optional BRANCH_CKPT_PERF_EN build only affects the top-level file.
package branch_ckpt_buffer_pkg;

   localparam int unsigned NUM_CKPT_DEF  = 4;
   localparam int unsigned ARCH_REGS_DEF = 32;
   localparam int unsigned PREG_W_DEF    = 7;
   localparam int unsigned PREGS_DEF     = 128;
   localparam int unsigned ROB_W_DEF     = 5;
   localparam int unsigned FL_PTR_W_DEF  = 7;

   localparam int unsigned CKPT_ID_W  = $clog2(NUM_CKPT_DEF);
   localparam int unsigned CKPT_MAP_W = ARCH_REGS_DEF * PREG_W_DEF;

   // One checkpoint at default widths, for monitors and scoreboards.
   typedef struct packed {
      logic                    valid;
      logic [31:0]             pc;
      logic [ROB_W_DEF-1:0]    rob_tag;
      logic [CKPT_MAP_W-1:0]   map;
      logic [FL_PTR_W_DEF-1:0] fl_rptr;
      logic [PREGS_DEF-1:0]    rdy;
   } ckpt_entry_t;

endpackage

// File: rtl/branch_ckpt_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping for the checkpoint ring, plus the mask of
// entries squashed by a mispredict (the resolved entry and everything younger).
module ckpt_ptr_ctrl
   import branch_ckpt_buffer_pkg::*;
#(
   parameter int unsigned  NumCkpt = NUM_CKPT_DEF,
   localparam int unsigned IdW     = $clog2(NumCkpt),
   localparam int unsigned CntW    = IdW + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic               mispredict_i,
   input  logic [IdW-1:0]     resolve_id_i,
   input  logic               head_valid_i,
   output logic [IdW-1:0]     head_o,
   output logic [IdW-1:0]     tail_o,
   output logic [CntW-1:0]    count_o,
   output logic [NumCkpt-1:0] squash_mask_o
);

   logic [IdW-1:0]  head_q, head_d;
   logic [IdW-1:0]  tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [IdW-1:0]  rpos;
   logic [IdW-1:0]  pos [NumCkpt];
   logic            reclaim;

   // Age of the resolved entry relative to head; wraps naturally (power of two).
   assign rpos    = resolve_id_i - head_q;
   assign reclaim = (count_q != '0) && !head_valid_i && !mispredict_i && !flush_i;

   always_comb begin
      squash_mask_o = '0;
      for (int i = 0; i < NumCkpt; i++) begin
         pos[i]           = IdW'(i) - head_q;
         squash_mask_o[i] = (pos[i] >= rpos);
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (mispredict_i) begin
         tail_d  = resolve_id_i + IdW'(1);
         count_d = {1'b0, rpos} + CntW'(1);
      end else begin
         if (alloc_i) tail_d = tail_q + IdW'(1);
         if (reclaim) head_d = head_q + IdW'(1);
         count_d = count_q + CntW'(alloc_i) - CntW'(reclaim);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;

endmodule

// File: rtl/branch_ckpt_buffer.sv
// Multi-entry branch checkpoint buffer: entry storage and registered restore bundle.
// Define BRANCH_CKPT_PERF_EN to add saturating perf_alloc/perf_mispredict/perf_full_stall.
module branch_ckpt_buffer
   import branch_ckpt_buffer_pkg::*;
#(
   parameter int unsigned  NUM_CKPT  = NUM_CKPT_DEF,
   parameter int unsigned  ARCH_REGS = ARCH_REGS_DEF,
   parameter int unsigned  PREG_W    = PREG_W_DEF,
   parameter int unsigned  PREGS     = PREGS_DEF,
   parameter int unsigned  ROB_W     = ROB_W_DEF,
   parameter int unsigned  FL_PTR_W  = FL_PTR_W_DEF,
   localparam int unsigned ID_W      = $clog2(NUM_CKPT),
   localparam int unsigned CNT_W     = ID_W + 1,
   localparam int unsigned MAP_W     = ARCH_REGS * PREG_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   output logic [ID_W-1:0]     alloc_id,
   input  logic [31:0]         alloc_pc,
   input  logic [ROB_W-1:0]    alloc_rob_tag,
   input  logic [MAP_W-1:0]    alloc_map,
   input  logic [FL_PTR_W-1:0] alloc_fl_rptr,
   input  logic [PREGS-1:0]    alloc_rdy,
   input  logic                resolve_valid,
   input  logic [ID_W-1:0]     resolve_id,
   input  logic                resolve_mispredict,
   output logic                restore_valid,
   output logic [31:0]         restore_pc,
   output logic [ROB_W-1:0]    restore_rob_tag,
   output logic [MAP_W-1:0]    restore_map,
   output logic [FL_PTR_W-1:0] restore_fl_rptr,
   output logic [PREGS-1:0]    restore_rdy,
   output logic [CNT_W-1:0]    count
`ifdef BRANCH_CKPT_PERF_EN
   ,
   output logic [31:0]         perf_alloc,
   output logic [31:0]         perf_mispredict,
   output logic [31:0]         perf_full_stall
`endif
);

   logic [NUM_CKPT-1:0] valid_q, valid_d;
   logic [NUM_CKPT-1:0] squash_mask;
   logic [ID_W-1:0]     head, tail;
   logic                alloc_fire, mp_fire, ok_fire, restore_fire;

   logic [31:0]         pc_q      [NUM_CKPT];
   logic [ROB_W-1:0]    rob_tag_q [NUM_CKPT];
   logic [MAP_W-1:0]    map_q     [NUM_CKPT];
   logic [FL_PTR_W-1:0] fl_rptr_q [NUM_CKPT];
   logic [PREGS-1:0]    rdy_q     [NUM_CKPT];

   logic                restore_valid_q;
   logic [31:0]         restore_pc_q;
   logic [ROB_W-1:0]    restore_rob_tag_q;
   logic [MAP_W-1:0]    restore_map_q;
   logic [FL_PTR_W-1:0] restore_fl_rptr_q;
   logic [PREGS-1:0]    restore_rdy_q;

   // Any mispredict request blocks allocation, even one naming a dead entry.
   assign alloc_ready  = (count < CNT_W'(NUM_CKPT)) && !flush &&
                         !(resolve_valid && resolve_mispredict);
   assign alloc_id     = tail;
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign mp_fire      = resolve_valid && resolve_mispredict && valid_q[resolve_id];
   assign ok_fire      = resolve_valid && !resolve_mispredict && valid_q[resolve_id];
   assign restore_fire = mp_fire && !flush;

   ckpt_ptr_ctrl #(
      .NumCkpt (NUM_CKPT)
   ) u_ptr_ctrl (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .alloc_i       (alloc_fire),
      .mispredict_i  (mp_fire),
      .resolve_id_i  (resolve_id),
      .head_valid_i  (valid_q[head]),
      .head_o        (head),
      .tail_o        (tail),
      .count_o       (count),
      .squash_mask_o (squash_mask)
   );

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = '0;
      end else if (mp_fire) begin
         valid_d = valid_q & ~squash_mask;
      end else begin
         if (ok_fire)    valid_d[resolve_id] = 1'b0;
         if (alloc_fire) valid_d[tail]       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Payload needs no reset: it is only observed through a valid entry.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         pc_q[tail]      <= alloc_pc;
         rob_tag_q[tail] <= alloc_rob_tag;
         map_q[tail]     <= alloc_map;
         fl_rptr_q[tail] <= alloc_fl_rptr;
         rdy_q[tail]     <= alloc_rdy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         restore_valid_q   <= 1'b0;
         restore_pc_q      <= '0;
         restore_rob_tag_q <= '0;
         restore_map_q     <= '0;
         restore_fl_rptr_q <= '0;
         restore_rdy_q     <= '0;
      end else begin
         restore_valid_q <= restore_fire;
         if (restore_fire) begin
            restore_pc_q      <= pc_q[resolve_id];
            restore_rob_tag_q <= rob_tag_q[resolve_id];
            restore_map_q     <= map_q[resolve_id];
            restore_fl_rptr_q <= fl_rptr_q[resolve_id];
            restore_rdy_q     <= rdy_q[resolve_id];
         end
      end
   end

   assign restore_valid   = restore_valid_q;
   assign restore_pc      = restore_pc_q;
   assign restore_rob_tag = restore_rob_tag_q;
   assign restore_map     = restore_map_q;
   assign restore_fl_rptr = restore_fl_rptr_q;
   assign restore_rdy     = restore_rdy_q;

`ifdef BRANCH_CKPT_PERF_EN
   logic [31:0] perf_alloc_q, perf_mispredict_q, perf_full_stall_q;
   logic        full_stall;

   assign full_stall = alloc_valid && (count == CNT_W'(NUM_CKPT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_alloc_q      <= '0;
         perf_mispredict_q <= '0;
         perf_full_stall_q <= '0;
      end else begin
         if (alloc_fire && (perf_alloc_q != '1))        perf_alloc_q      <= perf_alloc_q + 32'd1;
         if (restore_fire && (perf_mispredict_q != '1)) perf_mispredict_q <= perf_mispredict_q + 32'd1;
         if (full_stall && (perf_full_stall_q != '1))   perf_full_stall_q <= perf_full_stall_q + 32'd1;
      end
   end

   assign perf_alloc      = perf_alloc_q;
   assign perf_mispredict = perf_mispredict_q;
   assign perf_full_stall = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_branch_ckpt_buffer.sv
// Directed bench for branch_ckpt_buffer at default parameters.
module tb_branch_ckpt_buffer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         alloc_valid;
   logic         alloc_ready;
   logic [1:0]   alloc_id;
   logic [31:0]  alloc_pc;
   logic [4:0]   alloc_rob_tag;
   logic [223:0] alloc_map;
   logic [6:0]   alloc_fl_rptr;
   logic [127:0] alloc_rdy;
   logic         resolve_valid;
   logic [1:0]   resolve_id;
   logic         resolve_mispredict;
   logic         restore_valid;
   logic [31:0]  restore_pc;
   logic [4:0]   restore_rob_tag;
   logic [223:0] restore_map;
   logic [6:0]   restore_fl_rptr;
   logic [127:0] restore_rdy;
   logic [2:0]   count;
`ifdef BRANCH_CKPT_PERF_EN
   logic [31:0]  perf_alloc, perf_mispredict, perf_full_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_ckpt_buffer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush              (flush),
      .alloc_valid        (alloc_valid),
      .alloc_ready        (alloc_ready),
      .alloc_id           (alloc_id),
      .alloc_pc           (alloc_pc),
      .alloc_rob_tag      (alloc_rob_tag),
      .alloc_map          (alloc_map),
      .alloc_fl_rptr      (alloc_fl_rptr),
      .alloc_rdy          (alloc_rdy),
      .resolve_valid      (resolve_valid),
      .resolve_id         (resolve_id),
      .resolve_mispredict (resolve_mispredict),
      .restore_valid      (restore_valid),
      .restore_pc         (restore_pc),
      .restore_rob_tag    (restore_rob_tag),
      .restore_map        (restore_map),
      .restore_fl_rptr    (restore_fl_rptr),
      .restore_rdy        (restore_rdy),
      .count              (count)
`ifdef BRANCH_CKPT_PERF_EN
      ,
      .perf_alloc         (perf_alloc),
      .perf_mispredict    (perf_mispredict),
      .perf_full_stall    (perf_full_stall)
`endif
   );

   function automatic logic [31:0] pc_of(input int k);
      return 32'h100 + 32'(4 * k);
   endfunction
   function automatic logic [223:0] map_of(input int k);
      return {7{32'hA5A5_0000 + 32'(k)}};
   endfunction
   function automatic logic [6:0] fl_of(input int k);
      return 7'(10 + 3 * k);
   endfunction
   function automatic logic [127:0] rdy_of(input int k);
      return {4{32'h0F0F_0000 + 32'(k)}};
   endfunction
   function automatic logic [4:0] rob_of(input int k);
      return 5'(k + 1);
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns one time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic alloc(input string tag, input int k, input int exp_id);
      alloc_valid   = 1'b1;
      alloc_pc      = pc_of(k);
      alloc_rob_tag = rob_of(k);
      alloc_map     = map_of(k);
      alloc_fl_rptr = fl_of(k);
      alloc_rdy     = rdy_of(k);
      #1;
      chk({tag, "_ready"}, 256'(alloc_ready), 256'(1));
      chk({tag, "_id"}, 256'(alloc_id), 256'(exp_id));
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic resolve(input int id, input logic mp);
      resolve_valid      = 1'b1;
      resolve_id         = 2'(id);
      resolve_mispredict = mp;
      #1;
      tick();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
   endtask

   task automatic chk_restore(input string tag, input int k);
      chk({tag, "_rv"}, 256'(restore_valid), 256'(1));
      chk({tag, "_pc"}, 256'(restore_pc), 256'(pc_of(k)));
      chk({tag, "_rob"}, 256'(restore_rob_tag), 256'(rob_of(k)));
      chk({tag, "_map"}, 256'(restore_map), 256'(map_of(k)));
      chk({tag, "_fl"}, 256'(restore_fl_rptr), 256'(fl_of(k)));
      chk({tag, "_rdy"}, 256'(restore_rdy), 256'(rdy_of(k)));
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
      alloc_pc = '0; alloc_rob_tag = '0; alloc_map = '0; alloc_fl_rptr = '0; alloc_rdy = '0;
      resolve_valid = 1'b0; resolve_id = '0; resolve_mispredict = 1'b0;
      #3;
      chk("rst_count", 256'(count), 256'(0));
      chk("rst_rv", 256'(restore_valid), 256'(0));
      chk("rst_pc", 256'(restore_pc), 256'(0));
      chk("rst_map", 256'(restore_map), 256'(0));
      chk("rst_ready", 256'(alloc_ready), 256'(1));
      chk("rst_id", 256'(alloc_id), 256'(0));
      #9;
      rst_n = 1'b1;
      tick();

      // Fill the buffer, then hold a fifth request against a full buffer.
      for (int k = 0; k < 4; k++) alloc("fill", k, k);
      chk("full_count", 256'(count), 256'(4));
      chk("full_ready", 256'(alloc_ready), 256'(0));
      alloc_valid = 1'b1;
      alloc_pc    = 32'h200;
      #1;
      chk("held_ready", 256'(alloc_ready), 256'(0));
      tick();
      alloc_valid = 1'b0;
      chk("held_count", 256'(count), 256'(4));

      // Out-of-order correct resolves, then head reclaim one slot per cycle.
      resolve(1, 1'b0);
      chk("ok1_count", 256'(count), 256'(4));
      resolve(0, 1'b0);
      chk("ok0_count", 256'(count), 256'(4));
      tick();
      chk("reclaim1", 256'(count), 256'(3));
      tick();
      chk("reclaim2", 256'(count), 256'(2));
      tick();
      chk("reclaim_stop", 256'(count), 256'(2));
      // Head must be 2: mispredict on 2 leaves one slot, then it is reclaimed.
      resolve(2, 1'b1);
      chk_restore("head2_mp", 2);
      chk("head2_count", 256'(count), 256'(1));
      chk("head2_tail", 256'(alloc_id), 256'(3));
      tick();
      chk("head2_rv_off", 256'(restore_valid), 256'(0));
      chk("head2_drain", 256'(count), 256'(0));

      // Mispredict id 1 with four live entries.
      do_reset();
      for (int k = 0; k < 4; k++) alloc("t3", k, k);
      resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
      #1;
      chk("t3_block", 256'(alloc_ready), 256'(0));
      tick();
      resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      chk_restore("t3", 1);
      chk("t3_count", 256'(count), 256'(2));
      chk("t3_tail", 256'(alloc_id), 256'(2));
      tick();
      chk("t3_pulse", 256'(restore_valid), 256'(0));
      resolve(3, 1'b1);
      chk("t3_id3_dead", 256'(restore_valid), 256'(0));
      chk("t3_id3_count", 256'(count), 256'(2));
      resolve(2, 1'b1);
      chk("t3_id2_dead", 256'(restore_valid), 256'(0));
      resolve(0, 1'b1);
      chk_restore("t3_id0", 0);
      chk("t3_id0_count", 256'(count), 256'(1));

      // Wrap: move head to 3 (with an alloc overlapping a correct resolve).
      do_reset();
      alloc("t4a", 0, 0);
      alloc("t4b", 1, 1);
      resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b0;
      alloc("t4c", 2, 2);
      resolve_valid = 1'b0;
      chk("t4_both", 256'(count), 256'(3));
      resolve(1, 1'b0);
      chk("t4_r1", 256'(count), 256'(2));
      resolve(2, 1'b0);
      chk("t4_r2", 256'(count), 256'(1));
      tick();
      chk("t4_empty", 256'(count), 256'(0));
      chk("t4_tail3", 256'(alloc_id), 256'(3));
      alloc("t4w3", 10, 3);
      alloc("t4w0", 11, 0);
      alloc("t4w1", 12, 1);
      chk("t4_count3", 256'(count), 256'(3));
      resolve(0, 1'b1);
      chk_restore("t4_mp0", 11);
      chk("t4_mp0_count", 256'(count), 256'(2));
      chk("t4_mp0_tail", 256'(alloc_id), 256'(1));
      resolve(1, 1'b1);
      chk("t4_id1_dead", 256'(restore_valid), 256'(0));
      chk("t4_id1_count", 256'(count), 256'(2));
      resolve(3, 1'b1);
      chk_restore("t4_id3_kept", 10);
      chk("t4_id3_count", 256'(count), 256'(1));
      chk("t4_id3_tail", 256'(alloc_id), 256'(0));

      // Flush overrides a same-cycle mispredict.
      do_reset();
      for (int k = 0; k < 4; k++) alloc("t5", k, k);
      flush = 1'b1;
      resolve_valid = 1'b1; resolve_id = 2'd2; resolve_mispredict = 1'b1;
      #1;
      chk("t5_ready", 256'(alloc_ready), 256'(0));
      tick();
      flush = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      chk("t5_rv", 256'(restore_valid), 256'(0));
      chk("t5_count", 256'(count), 256'(0));
      chk("t5_tail", 256'(alloc_id), 256'(0));
      resolve(3, 1'b1);
      chk("t5_id3_dead", 256'(restore_valid), 256'(0));
      alloc("t5_re", 20, 0);
      resolve(0, 1'b1);
      chk_restore("t5_head0", 20);
      chk("t5_head0_count", 256'(count), 256'(1));

      // Asynchronous reset while a restore pulse is high.
      do_reset();
      for (int k = 30; k < 33; k++) alloc("t6", k, k - 30);
      resolve(2, 1'b1);
      chk("t6_rv_pre", 256'(restore_valid), 256'(1));
      chk("t6_count_pre", 256'(count), 256'(3));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rv", 256'(restore_valid), 256'(0));
      chk("t6_count", 256'(count), 256'(0));
      chk("t6_pc", 256'(restore_pc), 256'(0));
      chk("t6_id", 256'(alloc_id), 256'(0));
      #1;
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
